// File: rtl/multi_match_timer.sv
// multi_match_timer
//
// Multi-channel consecutive-match counter. Each channel counts consecutive
// enabled clock edges on which the shared input bus equals that channel's
// criterion, and pulses tick once the count reaches the shared goal. In
// one-shot mode a channel ticks once per sustained match; in repeat mode it
// ticks every cnt_goal edges while the match persists. A priority encoder
// reports the lowest channel currently held.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-low reset
//   en           global count enable; edges with en low freeze progress
//   repeat_mode  0 = one-shot, 1 = auto-repeat (all channels)
//   cnt_goal     matching edges required per tick; 0 disables all channels
//   in           shared sampled input bus
//   criterion    channel i criterion at bits [i*WIDTH +: WIDTH]
//   tick         per-channel one-cycle pulse (registered)
//   held         per-channel level: goal reached and still matching (registered)
//   hit_valid    any held bit set
//   hit_idx      lowest held channel index, 0 when none held

module multi_match_timer #(
    parameter int unsigned SIZE     = 32,
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned IDXW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      repeat_mode,
    input  logic [SIZE-1:0]           cnt_goal,
    input  logic [WIDTH-1:0]          in,
    input  logic [CHANNELS*WIDTH-1:0] criterion,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       held,
    output logic                      hit_valid,
    output logic [IDXW-1:0]           hit_idx
);

    logic [SIZE-1:0]     cnt_q [CHANNELS];
    logic [SIZE-1:0]     cnt_d [CHANNELS];
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic [CHANNELS-1:0] held_q, held_d;

    // One extra bit so the increment never wraps before the >= compare.
    logic [SIZE:0]       nxt [CHANNELS];
    logic [CHANNELS-1:0] match;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign match[g] = (in == criterion[g*WIDTH +: WIDTH]);
        assign nxt[g]   = {1'b0, cnt_q[g]} + {{SIZE{1'b0}}, 1'b1};
    end

    always_comb begin
        cnt_d  = cnt_q;
        held_d = held_q;
        tick_d = '0;
        if (en) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                if (cnt_goal == '0 || !match[i]) begin
                    cnt_d[i]  = '0;
                    held_d[i] = 1'b0;
                end else if (held_q[i] && !repeat_mode) begin
                    // One-shot and already fired: freeze the count so that a
                    // later switch to repeat mode resumes from here.
                    cnt_d[i] = cnt_q[i];
                end else if (nxt[i] >= {1'b0, cnt_goal}) begin
                    tick_d[i] = 1'b1;
                    held_d[i] = 1'b1;
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = nxt[i][SIZE-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt_q[i] <= '0;
            end
            tick_q <= '0;
            held_q <= '0;
        end else begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            tick_q <= tick_d;
            held_q <= held_d;
        end
    end

    // Scan high to low so the lowest held index is written last.
    always_comb begin
        hit_idx = '0;
        for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
            if (held_q[i]) begin
                hit_idx = IDXW'(i);
            end
        end
    end

    assign hit_valid = |held_q;
    assign tick      = tick_q;
    assign held      = held_q;

endmodule

// File: tb/tb_multi_match_timer.sv
// Table-driven bench for multi_match_timer. Each record is one clock edge:
// inputs driven before the edge, expected registered outputs after it.

module tb_multi_match_timer;

    localparam int unsigned SIZE     = 32;
    localparam int unsigned WIDTH    = 4;
    localparam int unsigned CHANNELS = 4;
    localparam int unsigned IDXW     = 2;

    // ch0=1, ch1=2, ch2=3, ch3=4
    localparam logic [15:0] CritBase  = 16'h4321;
    // ch1 and ch3 both = 2
    localparam logic [15:0] CritShare = 16'h2321;
    // ch1 moved to 5, ch3 still 2
    localparam logic [15:0] CritMoved = 16'h2351;

    logic                      clk;
    logic                      reset;
    logic                      en;
    logic                      repeat_mode;
    logic [SIZE-1:0]           cnt_goal;
    logic [WIDTH-1:0]          in;
    logic [CHANNELS*WIDTH-1:0] criterion;
    logic [CHANNELS-1:0]       tick;
    logic [CHANNELS-1:0]       held;
    logic                      hit_valid;
    logic [IDXW-1:0]           hit_idx;

    multi_match_timer #(
        .SIZE     (SIZE),
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .IDXW     (IDXW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .repeat_mode (repeat_mode),
        .cnt_goal    (cnt_goal),
        .in          (in),
        .criterion   (criterion),
        .tick        (tick),
        .held        (held),
        .hit_valid   (hit_valid),
        .hit_idx     (hit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic        rpt;
        logic [31:0] goal;
        logic [3:0]  in;
        logic [15:0] crit;
        logic [3:0]  exp_tick;
        logic [3:0]  exp_held;
        logic        exp_hv;
        logic [1:0]  exp_idx;
        int          scen;
    } vec_t;

    vec_t vecs[$];
    int   scen;
    int   checks;
    int   errors;

    task automatic add(input logic rst_n, input logic e, input logic rpt,
                       input logic [31:0] goal, input logic [3:0] din,
                       input logic [15:0] crit, input logic [3:0] t,
                       input logic [3:0] h, input logic hv, input logic [1:0] idx);
        vec_t v;
        v.rst_n    = rst_n;
        v.en       = e;
        v.rpt      = rpt;
        v.goal     = goal;
        v.in       = din;
        v.crit     = crit;
        v.exp_tick = t;
        v.exp_held = h;
        v.exp_hv   = hv;
        v.exp_idx  = idx;
        v.scen     = scen;
        vecs.push_back(v);
    endtask

    // Edge with no channel matching: everything clears.
    task automatic add_clear(input logic [31:0] goal);
        add(1'b1, 1'b1, 1'b0, goal, 4'h0, CritBase, 4'h0, 4'h0, 1'b0, 2'd0);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s vec %0d scen %0d: got %0h expected %0h",
                     name, idx, vecs[idx].scen, act, req);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // 0: reset state
        scen = 0;
        add(1'b0, 1'b1, 1'b0, 32'd5, 4'h1, CritBase, 4'h0, 4'h0, 1'b0, 2'd0);
        add(1'b0, 1'b1, 1'b0, 32'd5, 4'h1, CritBase, 4'h0, 4'h0, 1'b0, 2'd0);

        // 1: one-shot, goal 5, ch0 held for 20 edges
        scen = 1;
        for (int k = 1; k <= 20; k++) begin
            add(1'b1, 1'b1, 1'b0, 32'd5, 4'h1, CritBase,
                (k == 5) ? 4'h1 : 4'h0, (k >= 5) ? 4'h1 : 4'h0, k >= 5, 2'd0);
        end
        add_clear(32'd5);

        // 2: repeat, goal 3, ch2 for 10 edges
        scen = 2;
        for (int k = 1; k <= 10; k++) begin
            add(1'b1, 1'b1, 1'b1, 32'd3, 4'h3, CritBase,
                (k % 3 == 0) ? 4'h4 : 4'h0, (k >= 3) ? 4'h4 : 4'h0, k >= 3,
                (k >= 3) ? 2'd2 : 2'd0);
        end
        add_clear(32'd3);

        // 3: bounce, goal 4
        scen = 3;
        for (int k = 1; k <= 3; k++) begin
            add(1'b1, 1'b1, 1'b0, 32'd4, 4'h1, CritBase, 4'h0, 4'h0, 1'b0, 2'd0);
        end
        add(1'b1, 1'b1, 1'b0, 32'd4, 4'h0, CritBase, 4'h0, 4'h0, 1'b0, 2'd0);
        for (int k = 1; k <= 4; k++) begin
            add(1'b1, 1'b1, 1'b0, 32'd4, 4'h1, CritBase,
                (k == 4) ? 4'h1 : 4'h0, (k == 4) ? 4'h1 : 4'h0, k == 4, 2'd0);
        end
        add_clear(32'd4);

        // 4: en low window after 2 matches, goal 4
        scen = 4;
        add(1'b1, 1'b1, 1'b0, 32'd4, 4'h1, CritBase, 4'h0, 4'h0, 1'b0, 2'd0);
        add(1'b1, 1'b1, 1'b0, 32'd4, 4'h1, CritBase, 4'h0, 4'h0, 1'b0, 2'd0);
        for (int k = 1; k <= 3; k++) begin
            add(1'b1, 1'b0, 1'b0, 32'd4, 4'h1, CritBase, 4'h0, 4'h0, 1'b0, 2'd0);
        end
        add(1'b1, 1'b1, 1'b0, 32'd4, 4'h1, CritBase, 4'h0, 4'h0, 1'b0, 2'd0);
        add(1'b1, 1'b1, 1'b0, 32'd4, 4'h1, CritBase, 4'h1, 4'h1, 1'b1, 2'd0);
        // en low with a miss: held must survive
        add(1'b1, 1'b0, 1'b0, 32'd4, 4'h0, CritBase, 4'h0, 4'h1, 1'b1, 2'd0);
        add_clear(32'd4);

        // 5: goal 0 never ticks
        scen = 5;
        for (int k = 1; k <= 6; k++) begin
            add(1'b1, 1'b1, 1'b0, 32'd0, 4'h1, CritBase, 4'h0, 4'h0, 1'b0, 2'd0);
        end

        // 6: goal lowered 10 -> 2 with cnt 6
        scen = 6;
        for (int k = 1; k <= 6; k++) begin
            add(1'b1, 1'b1, 1'b0, 32'd10, 4'h1, CritBase, 4'h0, 4'h0, 1'b0, 2'd0);
        end
        add(1'b1, 1'b1, 1'b0, 32'd2, 4'h1, CritBase, 4'h1, 4'h1, 1'b1, 2'd0);
        add(1'b1, 1'b1, 1'b0, 32'd2, 4'h1, CritBase, 4'h0, 4'h1, 1'b1, 2'd0);
        add_clear(32'd2);

        // 7: reset mid-count while held (repeat, goal 3)
        scen = 7;
        add(1'b1, 1'b1, 1'b1, 32'd3, 4'h1, CritBase, 4'h0, 4'h0, 1'b0, 2'd0);
        add(1'b1, 1'b1, 1'b1, 32'd3, 4'h1, CritBase, 4'h0, 4'h0, 1'b0, 2'd0);
        add(1'b1, 1'b1, 1'b1, 32'd3, 4'h1, CritBase, 4'h1, 4'h1, 1'b1, 2'd0);
        add(1'b1, 1'b1, 1'b1, 32'd3, 4'h1, CritBase, 4'h0, 4'h1, 1'b1, 2'd0);
        add(1'b1, 1'b1, 1'b1, 32'd3, 4'h1, CritBase, 4'h0, 4'h1, 1'b1, 2'd0);
        add(1'b0, 1'b1, 1'b1, 32'd3, 4'h1, CritBase, 4'h0, 4'h0, 1'b0, 2'd0);
        add(1'b1, 1'b1, 1'b1, 32'd3, 4'h1, CritBase, 4'h0, 4'h0, 1'b0, 2'd0);
        add(1'b1, 1'b1, 1'b1, 32'd3, 4'h1, CritBase, 4'h0, 4'h0, 1'b0, 2'd0);
        add(1'b1, 1'b1, 1'b1, 32'd3, 4'h1, CritBase, 4'h1, 4'h1, 1'b1, 2'd0);
        add_clear(32'd3);

        // 8: ch1 and ch3 share a criterion
        scen = 8;
        add(1'b1, 1'b1, 1'b0, 32'd2, 4'h2, CritShare, 4'h0, 4'h0, 1'b0, 2'd0);
        add(1'b1, 1'b1, 1'b0, 32'd2, 4'h2, CritShare, 4'hA, 4'hA, 1'b1, 2'd1);
        add(1'b1, 1'b1, 1'b0, 32'd2, 4'h2, CritMoved, 4'h0, 4'h8, 1'b1, 2'd3);
        add_clear(32'd2);

        // 9: repeat_mode toggled while held, then goal 1 continuous ticks
        scen = 9;
        add(1'b1, 1'b1, 1'b1, 32'd2, 4'h1, CritBase, 4'h0, 4'h0, 1'b0, 2'd0);
        add(1'b1, 1'b1, 1'b1, 32'd2, 4'h1, CritBase, 4'h1, 4'h1, 1'b1, 2'd0);
        add(1'b1, 1'b1, 1'b1, 32'd2, 4'h1, CritBase, 4'h0, 4'h1, 1'b1, 2'd0);
        add(1'b1, 1'b1, 1'b0, 32'd2, 4'h1, CritBase, 4'h0, 4'h1, 1'b1, 2'd0);
        add(1'b1, 1'b1, 1'b0, 32'd2, 4'h1, CritBase, 4'h0, 4'h1, 1'b1, 2'd0);
        // cnt was frozen at 1, so resuming repeat ticks immediately
        add(1'b1, 1'b1, 1'b1, 32'd2, 4'h1, CritBase, 4'h1, 4'h1, 1'b1, 2'd0);
        for (int k = 1; k <= 3; k++) begin
            add(1'b1, 1'b1, 1'b1, 32'd1, 4'h1, CritBase, 4'h1, 4'h1, 1'b1, 2'd0);
        end
        add(1'b1, 1'b1, 1'b0, 32'd1, 4'h1, CritBase, 4'h0, 4'h1, 1'b1, 2'd0);
        add_clear(32'd1);

        reset       = 1'b0;
        en          = 1'b0;
        repeat_mode = 1'b0;
        cnt_goal    = '0;
        in          = '0;
        criterion   = CritBase;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset       = vecs[i].rst_n;
            en          = vecs[i].en;
            repeat_mode = vecs[i].rpt;
            cnt_goal    = vecs[i].goal;
            in          = vecs[i].in;
            criterion   = vecs[i].crit;
            @(posedge clk);
            #1;
            check("tick", i, 32'(tick), 32'(vecs[i].exp_tick));
            check("held", i, 32'(held), 32'(vecs[i].exp_held));
            check("hit_valid", i, 32'(hit_valid), 32'(vecs[i].exp_hv));
            check("hit_idx", i, 32'(hit_idx), 32'(vecs[i].exp_idx));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_match_timer.md
# multi_match_timer

Parametrised multi-channel successor to the single-channel match counter used for keypad debounce. Each channel counts consecutive clock edges on which the shared input bus equals that channel's criterion, and pulses `tick` once the count reaches a shared goal. A mode input selects one-shot behaviour (debounce: single tick per press) or repeat behaviour (auto-repeat: a tick every `cnt_goal` cycles while held). A priority-encoded hit output reports the lowest held channel to the keypad scanner FSM.

## Interface
- `SIZE`, 32: counter and goal width in bits.
- `WIDTH`, 4: width of the input bus and of each criterion.
- `CHANNELS`, 4: number of independent match channels, 1..16.
- `IDXW`, `$clog2(CHANNELS)` (minimum 1): width of `hit_idx`.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low.
- `en`  in  1  global count enable.
- `repeat_mode`  in  1  0 = one-shot, 1 = auto-repeat; applies to all channels.
- `cnt_goal`  in  SIZE  consecutive matching edges required per tick; 0 disables all channels.
- `in`  in  WIDTH  shared sampled input bus.
- `criterion`  in  CHANNELS*WIDTH  channel i criterion at bits [i*WIDTH +: WIDTH].
- `tick`  out  CHANNELS  per-channel one-cycle pulse, registered.
- `held`  out  CHANNELS  per-channel level: goal reached and still matching, registered.
- `hit_valid`  out  1  high when any `held` bit is set.
- `hit_idx`  out  IDXW  lowest index i with `held[i]` set; 0 when `hit_valid` = 0.

## Operation
- Per channel: `cnt[i]` (SIZE bits), `held[i]`, `tick[i]`. `match_i` = (`in` == criterion slice i).
- Reset (`reset` = 0 at edge): all `cnt` = 0, `tick` = 0, `held` = 0; takes priority over `en`.
- `en` = 0: `cnt` and `held` hold their values; `tick` = 0.
- `en` = 1, evaluated per channel at each edge, in priority order:
  - `cnt_goal` = 0: `cnt` <= 0, `held` <= 0, `tick` <= 0.
  - `match_i` = 0: `cnt` <= 0, `held` <= 0, `tick` <= 0.
  - `held` = 1 and `repeat_mode` = 0: `cnt` holds, `tick` <= 0.
  - Otherwise `nxt` = `cnt` + 1. If `nxt` >= `cnt_goal`: `tick` <= 1, `held` <= 1, `cnt` <= 0. Else `cnt` <= `nxt`, `tick` <= 0.
- The compare is >=, so lowering `cnt_goal` below the current count fires on the next matching edge with no wrap-around.
- Channels are independent; several channels with equal criteria tick in the same cycle.
- `hit_valid` and `hit_idx` are combinational from the `held` register only.
- `repeat_mode` is sampled every edge. Switching 1→0 while held stops further ticks; switching 0→1 while held resumes counting from the current `cnt`.

## Timing
- `tick[i]` rises in the cycle after the `cnt_goal`-th consecutive matching edge with `en` high, counting from a zero count. The first matching edge counts as 1.
- A one-shot tick is exactly one cycle wide. Its width is independent of how long the match persists.
- Repeat mode: ticks are spaced `cnt_goal` cycles apart. With `cnt_goal` = 1, `tick` stays high continuously while matching.
- `held` rises together with the first `tick`. It falls in the cycle after the first non-matching edge.
- A single non-matching edge clears progress. The next match restarts the count at 1.
- Edges with `en` low neither advance nor clear progress.
- Reset outputs: `tick` = 0, `held` = 0, `hit_valid` = 0, `hit_idx` = 0.

## Test plan
- CHANNELS=4, goal=5, one-shot, criterion0=4'b0001, `in` held at 0001 for 20 cycles: exactly one `tick[0]`, 5 cycles after the first match edge. `held[0]` stays 1 until `in` changes. `hit_idx` = 0.
- Repeat mode, goal=3, `in` matches ch2 for 10 edges: `tick[2]` high at cycles 3, 6 and 9 after the start. `held[2]` = 1 from cycle 3 onward.
- Bounce: goal=4, pattern match,match,match,miss,match×4: no tick on the first run. Tick 4 cycles after the second run starts.
- `en` dropped for 3 cycles after 2 matching edges (goal=4), then re-raised while matching: tick after 2 more edges. `tick` = 0 throughout the `en`-low window.
- Boundaries: goal=0 with matching `in` gives no tick ever. Goal lowered from 10 to 2 with `cnt`=6 gives a tick on the next edge. `reset` low mid-count clears all outputs on that edge.
- Channels 1 and 3 share a criterion and match simultaneously: both ticks fire in the same cycle. `hit_idx` = 1. After ch1's criterion changes, `hit_idx` = 3.
